pwm_multichannel: RTL and testbench
===================================

// Module: pwm_multichannel
// PURPOSE
//  NUM_CH-channel PWM generator behind one command-bus register port; next-generation PWM block.
//  Each channel has its own period, duty, prescaler, alignment mode and polarity.
//  Duty/period updates are glitch-free, taking effect at the period boundary.
//  Prescaling is a clock enable, not a derived clock; everything runs on Clk.
// PARAMETERS
//  NUM_CH    4   number of PWM channels (1..8)
//  CNT_W     16  width of period/duty/counter (8..16)
//  PRESC_W   3   prescaler exponent width; tick every 2**presc Clk cycles
//  ADDR_W    5   command address width; must be >= clog2(NUM_CH)+2
// PORTS
//  Clk            in   1          system clock, rising edge
//  Reset          in   1          asynchronous, active-high reset
//  CmdVal         in   1          command valid
//  CmdRW          in   1          1 = read, 0 = write
//  CmdAddr        in   ADDR_W     {channel, reg[1:0]}
//  CmdDataIn      in   16         write data
//  CmdDataOut     out  16         read data, registered
//  CmdDataOutVal  out  1          one-cycle strobe qualifying CmdDataOut
//  OE             in   1          global output enable
//  PWM_out        out  NUM_CH     PWM waveforms
//  PeriodEnd      out  NUM_CH     one-cycle pulse per channel at counter wrap
// BEHAVIOUR
//  Register map, per channel (reg field):
//   - 0 PERIOD[CNT_W-1:0]
//   - 1 DUTY[CNT_W-1:0]
//   - 2 CTRL: bit0 start, bit1 invert, bit2 center
//   - 3 PRESC[PRESC_W-1:0]
//   - Unused data bits: write-ignored, read as 0.
//  Reset: all registers, counters and outputs are 0; PWM_out=0, PeriodEnd=0, CmdDataOut=0, CmdDataOutVal=0.
//  Write (CmdVal=1, CmdRW=0) updates the shadow register on the next edge.
//   - CTRL and PRESC apply immediately.
//   - PERIOD and DUTY shadows copy to active when the counter wraps, or immediately while start=0.
//  Read (CmdVal=1, CmdRW=1): CmdDataOut = shadow value one cycle later, with CmdDataOutVal=1. Otherwise CmdDataOutVal=0 and CmdDataOut holds its value.
//  Channel index >= NUM_CH: writes are ignored; reads return 0 with CmdDataOutVal=1.
//  Prescaler: per-channel count; tick=1 when count == 2**PRESC-1, then count clears. PRESC=0 gives tick every cycle. Count clears when start=0.
//  Edge mode (center=0), advancing on tick:
//   - cnt 0..PERIOD-1, then wraps to 0; PeriodEnd pulses on the wrap cycle.
//   - raw = (cnt < DUTY).
//  Center mode (center=1):
//   - cnt counts up 0..PERIOD-1, then down PERIOD-1..0, so one cycle is 2*PERIOD ticks.
//   - raw = (cnt < DUTY).
//   - PeriodEnd and the shadow load happen when cnt returns to 0 going down.
//  Boundaries:
//   - DUTY=0 gives raw=0 constantly.
//   - DUTY>=PERIOD gives raw=1 constantly.
//   - PERIOD=0 gives raw=0, cnt held at 0, and no PeriodEnd.
//   - PERIOD=1 in center mode behaves as edge mode with period 1.
//  Output: PWM_out[i] = OE & start ? (raw ^ invert) : 0, registered, one Clk after the cnt update.
//  start 1->0: cnt, prescale count and direction clear on the next edge; output goes 0.
//  start 0->1: the first tick occurs 2**PRESC cycles later.
//  A write and a wrap in the same cycle: the wrap loads the old shadow; the new value loads at the next wrap.
//  Reset asserted mid-period: immediate return to reset state.
// STRUCTURE
//  - Shared header define.v gains PWM_REG_PERIOD/DUTY/CTRL/PRESC offsets, CTRL bit positions and reset values.
//  - Sub-module pwm_channel: prescaler, counter, direction flag, shadow/active regs, compare and output flop.
//  - Top pwm_multichannel: address decode, per-channel write enables, read mux and generate loop over NUM_CH.
// TESTING
//  1 Reset, then PERIOD=4, DUTY=1, CTRL=1, PRESC=0 on ch0 -> PWM_out[0] repeats 1000; PeriodEnd every 4 cycles.
//  2 ch1 PRESC=2, PERIOD=4, DUTY=2 -> high 8 Clk, low 8 Clk; PeriodEnd every 16 Clk.
//  3 ch0 running with DUTY=1; write DUTY=3 mid-period -> current period unchanged; next period 1110.
//  4 ch2 center=1, PERIOD=4, DUTY=2 -> 8-tick cycle, symmetric pattern 11000011 over the cycle.
//  5 DUTY=0 -> constant 0; DUTY=9 with PERIOD=4 -> constant 1; PERIOD=0 -> constant 0; invert=1 -> complements; OE=0 -> all 0.
//  6 Read back PERIOD from ch3, and from channel 5 with NUM_CH=4 -> value/0 one cycle later, CmdDataOutVal pulse; Reset mid-period -> all outputs 0 immediately.

Source files
------------

// File: rtl/pwm_multichannel_pkg.sv
// pwm_multichannel_pkg
//   Shared definitions for the multichannel PWM block: register offsets
//   within a channel, CTRL bit layout and register reset values.
package pwm_multichannel_pkg;

    localparam int DATA_W = 16;

    // Register offsets (CmdAddr[1:0])
    typedef enum logic [1:0] {
        PWM_REG_PERIOD = 2'd0,
        PWM_REG_DUTY   = 2'd1,
        PWM_REG_CTRL   = 2'd2,
        PWM_REG_PRESC  = 2'd3
    } pwm_reg_e;

    // CTRL bit positions
    localparam int PWM_CTRL_START  = 0;
    localparam int PWM_CTRL_INVERT = 1;
    localparam int PWM_CTRL_CENTER = 2;

    typedef struct packed {
        logic center;
        logic invert;
        logic start;
    } pwm_ctrl_t;

    // Reset values
    localparam logic [DATA_W-1:0] PWM_PERIOD_RST = '0;
    localparam logic [DATA_W-1:0] PWM_DUTY_RST   = '0;
    localparam pwm_ctrl_t         PWM_CTRL_RST   = '0;

endpackage

// File: rtl/pwm_multichannel_channel.sv
// pwm_channel
//   One PWM channel: shadow/active PERIOD and DUTY, CTRL and PRESC
//   registers, prescaler clock enable, up or up/down counter, compare and
//   registered output.
// Ports:
//   clk, rst      clock, async active-high reset
//   oe            global output enable
//   wr_en         write strobe for this channel
//   reg_sel       register offset for write and read-back
//   wr_data       write data
//   rd_data       shadow value of reg_sel (combinational, zero-extended)
//   pwm           registered PWM output
//   period_end    one-cycle pulse on counter wrap
module pwm_channel
    import pwm_multichannel_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              oe,
    input  logic              wr_en,
    input  logic [1:0]        reg_sel,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              pwm,
    output logic              period_end
);
    localparam int PCNT_W = (1 << PRESC_W) - 1;

    logic [CNT_W-1:0]   sh_period, sh_duty, act_period, act_duty, cnt, cnt_nxt;
    logic [PRESC_W-1:0] presc;
    logic [PCNT_W-1:0]  pcnt, pmask;
    pwm_ctrl_t          ctrl;
    logic dir, dir_nxt, tick, edge_mode, at_top, wrap_pt, wrap, load, raw;

    assign pmask     = PCNT_W'((32'd1 << presc) - 32'd1);
    // >= so a PRESC reduction mid-count still ticks right away
    assign tick      = ctrl.start && (pcnt >= pmask);
    assign edge_mode = !ctrl.center || (act_period == CNT_W'(1));
    assign at_top    = (cnt >= act_period - CNT_W'(1));
    assign wrap      = tick && wrap_pt;
    // With PERIOD=0 the counter never wraps; loading freely is glitch-free
    // since cnt is parked at 0 and the output is forced low.
    assign load      = wrap || !ctrl.start || (act_period == '0);
    assign raw       = (act_period != '0) && (cnt < act_duty);

    // Counter successor, applied only on tick. dir=1 means counting down.
    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir;
        wrap_pt = 1'b0;
        if (act_period == '0) begin
            cnt_nxt = '0;
            dir_nxt = 1'b0;
        end else if (edge_mode) begin
            dir_nxt = 1'b0;
            if (at_top) begin
                cnt_nxt = '0;
                wrap_pt = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else if (!dir) begin
            // top value is held for two ticks: once up, once down
            if (at_top) dir_nxt = 1'b1;
            else        cnt_nxt = cnt + CNT_W'(1);
        end else if (cnt == '0) begin
            dir_nxt = 1'b0;
            wrap_pt = 1'b1;
        end else begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_period  <= PWM_PERIOD_RST[CNT_W-1:0];
            sh_duty    <= PWM_DUTY_RST[CNT_W-1:0];
            act_period <= PWM_PERIOD_RST[CNT_W-1:0];
            act_duty   <= PWM_DUTY_RST[CNT_W-1:0];
            ctrl       <= PWM_CTRL_RST;
            presc      <= '0;
            pcnt       <= '0;
            cnt        <= '0;
            dir        <= 1'b0;
            pwm        <= 1'b0;
            period_end <= 1'b0;
        end else begin
            if (wr_en) begin
                case (reg_sel)
                    PWM_REG_PERIOD: sh_period <= wr_data[CNT_W-1:0];
                    PWM_REG_DUTY:   sh_duty   <= wr_data[CNT_W-1:0];
                    PWM_REG_CTRL:   ctrl      <= pwm_ctrl_t'(wr_data[2:0]);
                    default:        presc     <= wr_data[PRESC_W-1:0];
                endcase
            end
            // active regs take the pre-write shadow when a write meets a wrap
            if (load) begin
                act_period <= sh_period;
                act_duty   <= sh_duty;
            end
            if (!ctrl.start) begin
                pcnt <= '0;
                cnt  <= '0;
                dir  <= 1'b0;
            end else begin
                pcnt <= tick ? '0 : pcnt + PCNT_W'(1);
                if (tick) begin
                    cnt <= cnt_nxt;
                    dir <= dir_nxt;
                end
            end
            period_end <= wrap;
            pwm        <= oe && ctrl.start && (raw ^ ctrl.invert);
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            PWM_REG_PERIOD: rd_data = DATA_W'(sh_period);
            PWM_REG_DUTY:   rd_data = DATA_W'(sh_duty);
            PWM_REG_CTRL:   rd_data = DATA_W'(ctrl);
            default:        rd_data = DATA_W'(presc);
        endcase
    end

endmodule

// File: rtl/pwm_multichannel.sv
// pwm_multichannel
//   NUM_CH-channel PWM generator behind one command-bus register port.
//   CmdAddr = {channel, reg[1:0]}; channels >= NUM_CH ignore writes and
//   read back 0.
// Ports:
//   Clk, Reset            clock, async active-high reset
//   CmdVal/CmdRW/CmdAddr  command valid, 1=read 0=write, address
//   CmdDataIn             write data
//   CmdDataOut/Val        registered read data and its one-cycle strobe
//   OE                    global output enable
//   PWM_out, PeriodEnd    per-channel waveform and wrap pulse
module pwm_multichannel
    import pwm_multichannel_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 3,
    parameter int ADDR_W  = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              CmdVal,
    input  logic              CmdRW,
    input  logic [ADDR_W-1:0] CmdAddr,
    input  logic [15:0]       CmdDataIn,
    output logic [15:0]       CmdDataOut,
    output logic              CmdDataOutVal,
    input  logic              OE,
    output logic [NUM_CH-1:0] PWM_out,
    output logic [NUM_CH-1:0] PeriodEnd
);
    localparam int CH_W = ADDR_W - 2;

    logic [CH_W-1:0]               ch_idx;
    logic [1:0]                    reg_sel;
    logic [NUM_CH-1:0]             wr_en;
    logic [NUM_CH-1:0][DATA_W-1:0] rd_val;
    logic [DATA_W-1:0]             rd_mux;

    assign ch_idx  = CmdAddr[ADDR_W-1:2];
    assign reg_sel = CmdAddr[1:0];

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign wr_en[i] = CmdVal && !CmdRW && (ch_idx == CH_W'(i));
            pwm_channel #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) u_ch (
                .clk        (Clk),
                .rst        (Reset),
                .oe         (OE),
                .wr_en      (wr_en[i]),
                .reg_sel    (reg_sel),
                .wr_data    (CmdDataIn),
                .rd_data    (rd_val[i]),
                .pwm        (PWM_out[i]),
                .period_end (PeriodEnd[i])
            );
        end
    endgenerate

    // unmatched (out-of-range) channel falls through to 0
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (ch_idx == CH_W'(i)) rd_mux = rd_val[i];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            CmdDataOut    <= '0;
            CmdDataOutVal <= 1'b0;
        end else begin
            CmdDataOutVal <= CmdVal && CmdRW;
            if (CmdVal && CmdRW) CmdDataOut <= rd_mux;
        end
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel
//   Directed bench for pwm_multichannel (NUM_CH=4, CNT_W=16, PRESC_W=3).
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge. Waveform windows start at a PeriodEnd cycle k=0; PWM_out in cycle
//   k reflects the counter value of cycle k-1.
module tb_pwm_multichannel;
    logic        Clk = 1'b0;
    logic        Reset, CmdVal, CmdRW, OE;
    logic [4:0]  CmdAddr;
    logic [15:0] CmdDataIn, CmdDataOut;
    logic        CmdDataOutVal;
    logic [3:0]  PWM_out, PeriodEnd;

    int total = 0;
    int bad   = 0;
    logic [31:0] v;
    int n;

    always #5 Clk = ~Clk;

    pwm_multichannel #(.NUM_CH(4), .CNT_W(16), .PRESC_W(3), .ADDR_W(5)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .CmdVal        (CmdVal),
        .CmdRW         (CmdRW),
        .CmdAddr       (CmdAddr),
        .CmdDataIn     (CmdDataIn),
        .CmdDataOut    (CmdDataOut),
        .CmdDataOutVal (CmdDataOutVal),
        .OE            (OE),
        .PWM_out       (PWM_out),
        .PeriodEnd     (PeriodEnd)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge Clk);
    endtask

    task automatic wr(input int ch, input int r, input logic [15:0] d);
        CmdVal = 1'b1; CmdRW = 1'b0; CmdAddr = 5'(ch * 4 + r); CmdDataIn = d;
        @(negedge Clk);
        CmdVal = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int ch, input int r, input logic [15:0] exp);
        CmdVal = 1'b1; CmdRW = 1'b1; CmdAddr = 5'(ch * 4 + r);
        @(negedge Clk);
        CmdVal = 1'b0; CmdRW = 1'b0;
        chk({tag, "_val"}, 32'(CmdDataOutVal), 32'd1);
        chk(tag, 32'(CmdDataOut), 32'(exp));
        @(negedge Clk);
        chk({tag, "_hold"}, 32'({CmdDataOutVal, CmdDataOut}), 32'({1'b0, exp}));
    endtask

    task automatic wait_pe(input int ch, input string tag);
        int k = 0;
        do begin @(negedge Clk); k++; end while (!PeriodEnd[ch] && k < 200);
        chk({tag, "_pe_seen"}, 32'(PeriodEnd[ch]), 32'd1);
    endtask

    task automatic pe_gap(input int ch, output int k);
        k = 0;
        do begin @(negedge Clk); k++; end while (!PeriodEnd[ch] && k < 100);
    endtask

    // first sample lands in the MSB
    task automatic samp(input int ch, input int k, output logic [31:0] s);
        s = '0;
        repeat (k) begin @(negedge Clk); s = {s[30:0], PWM_out[ch]}; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; CmdVal = 1'b0; CmdRW = 1'b0; CmdAddr = '0; CmdDataIn = '0; OE = 1'b1;
        cyc(2);
        chk("reset_outs", 32'({PWM_out, PeriodEnd, CmdDataOutVal, CmdDataOut}), 32'd0);
        Reset = 1'b0;
        cyc(1);

        // 1: edge mode P=4 D=1 -> 1000
        wr(0, 0, 16'd4); wr(0, 1, 16'd1); wr(0, 3, 16'd0); wr(0, 2, 16'd1);
        wait_pe(0, "t1");
        samp(0, 8, v);   chk("t1_pattern", v, 32'h88);
        pe_gap(0, n);    chk("t1_pe_gap", 32'(n), 32'd4);

        // 2: PRESC=2 P=4 D=2 -> 8 high, 8 low, PeriodEnd every 16
        wr(1, 3, 16'd2); wr(1, 0, 16'd4); wr(1, 1, 16'd2); wr(1, 2, 16'd1);
        wait_pe(1, "t2");
        samp(1, 16, v);  chk("t2_pattern", v, 32'hFF00);
        pe_gap(1, n);    chk("t2_pe_gap", 32'(n), 32'd16);

        // 3: DUTY 1->3 mid-period; samples k2..k9: 000 (old) then 1110 (new)
        wait_pe(0, "t3");
        wr(0, 1, 16'd3);
        samp(0, 8, v);   chk("t3_glitchfree", v, 32'h1D);

        // 4: center mode P=4 D=2 -> 11000011 over 8 ticks
        wr(2, 0, 16'd4); wr(2, 1, 16'd2); wr(2, 2, 16'd5);
        wait_pe(2, "t4");
        samp(2, 8, v);   chk("t4_center", v, 32'hC3);
        pe_gap(2, n);    chk("t4_pe_gap", 32'(n), 32'd8);

        // 5: boundaries on ch0
        wr(0, 1, 16'd0); cyc(10);
        samp(0, 8, v);   chk("t5_duty0", v, 32'h00);
        wr(0, 1, 16'd9); cyc(10);
        samp(0, 8, v);   chk("t5_duty_ge_period", v, 32'hFF);
        wr(0, 0, 16'd0); cyc(10);
        samp(0, 8, v);   chk("t5_period0", v, 32'h00);
        n = 0;
        repeat (12) begin @(negedge Clk); n += int'(PeriodEnd[0]); end
        chk("t5_period0_no_pe", 32'(n), 32'd0);
        wr(0, 1, 16'd1); wr(0, 0, 16'd4); wr(0, 2, 16'd3);
        cyc(2);
        wait_pe(0, "t5_inv");
        samp(0, 4, v);   chk("t5_invert", v, 32'h7);
        OE = 1'b0;
        cyc(2);
        v = '0;
        repeat (8) begin @(negedge Clk); v = v | 32'(PWM_out); end
        chk("t5_oe_off", v, 32'd0);
        OE = 1'b1;

        // 6: read-back, out-of-range channel, unused bits, mid-period reset
        wr(3, 0, 16'h1234);
        rd_chk("rd_ch3_period", 3, 0, 16'h1234);
        wr(5, 0, 16'hBEEF);
        rd_chk("rd_ch5_period", 5, 0, 16'h0000);
        rd_chk("rd_ch1_duty", 1, 1, 16'd2);
        wr(3, 2, 16'hFFFF);
        rd_chk("rd_ch3_ctrl", 3, 2, 16'h0007);
        wr(3, 3, 16'hFFFF);
        rd_chk("rd_ch3_presc", 3, 3, 16'h0007);

        cyc(3);
        #2 Reset = 1'b1;
        #1 chk("reset_mid", 32'({PWM_out, PeriodEnd, CmdDataOutVal, CmdDataOut}), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        v = '0;
        repeat (10) begin @(negedge Clk); v = v | 32'({PWM_out, PeriodEnd}); end
        chk("post_reset_idle", v, 32'd0);
        rd_chk("rd_ch0_ctrl_rst", 0, 2, 16'd0);
        rd_chk("rd_ch0_period_rst", 0, 0, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
